// File: rtl/conv_feature_streamer_pkg.sv
// Shared constants for the feature-map streamer: final pool-stage geometry,
// default word width and the FSM state encoding.
package conv_feature_streamer_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 16;

   // Final max-pool stage output geometry
   localparam int unsigned POOL3_SIDE  = 3;
   localparam int unsigned POOL3_DEPTH = 32;
   localparam int unsigned WORDS_DEF   = POOL3_SIDE * POOL3_SIDE * POOL3_DEPTH;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

endpackage : conv_feature_streamer_pkg

// File: rtl/conv_feature_streamer.sv
// Snapshots the flat feature-map bus on start and streams it out one word per
// valid/ready transfer, flagging the last word and pulsing done afterwards.
module conv_feature_streamer
   import conv_feature_streamer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned WORDS      = WORDS_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [WORDS*DATA_WIDTH-1:0]   featIn,
   output logic [DATA_WIDTH-1:0]         outData,
   output logic                          outValid,
   input  logic                          outReady,
   output logic                          outLast,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int unsigned BUS_W = WORDS * DATA_WIDTH;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    last_q, last_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [BUS_W-1:0]        buf_q;
   logic                    buf_load;
   logic                    buf_shift;

   // Next-state and registered-output decode
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      data_d    = data_q;
      valid_d   = valid_q;
      last_d    = last_q;
      done_d    = 1'b0;
      buf_load  = 1'b0;
      buf_shift = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
            if (start) begin
               state_d  = ST_STREAM;
               idx_d    = '0;
               valid_d  = 1'b1;
               data_d   = featIn[DATA_WIDTH-1:0];
               last_d   = (WORDS == 1);
               buf_load = 1'b1;
            end
         end
         ST_STREAM: begin
            if (valid_q && outReady) begin
               if (last_q) begin
                  state_d = ST_DONE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  data_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d     = idx_q + IDX_W'(1);
                  data_d    = buf_q[DATA_WIDTH-1:0];
                  buf_shift = 1'b1;
                  last_d    = (idx_d == IDX_W'(WORDS - 1));
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Remaining words queue up behind outData; word 0 goes straight to the output
   always_ff @(posedge clk) begin
      if (buf_load) begin
         buf_q <= featIn >> DATA_WIDTH;
      end else if (buf_shift) begin
         buf_q <= buf_q >> DATA_WIDTH;
      end
   end

   assign outData  = data_q;
   assign outValid = valid_q;
   assign outLast  = last_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule : conv_feature_streamer

// File: tb/tb_conv_feature_streamer.sv
// Scoreboard bench for conv_feature_streamer with WORDS=4, WORDS=1 and WORDS=288 instances.
module tb_conv_feature_streamer;

   typedef struct packed {
      logic [15:0] d;
      logic        l;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- instance A: WORDS=4
   logic        start_a, ready_a, valid_a, last_a, busy_a, done_a;
   logic [63:0] feat_a;
   logic [15:0] data_a;
   exp_t        q_a[$];
   int          done_cnt_a = 0;

   conv_feature_streamer #(.DATA_WIDTH(16), .WORDS(4)) u_a (
      .clk(clk), .reset(rst), .start(start_a), .featIn(feat_a),
      .outData(data_a), .outValid(valid_a), .outReady(ready_a),
      .outLast(last_a), .busy(busy_a), .done(done_a));

   // ---------------- instance B: WORDS=1
   logic        start_b, ready_b, valid_b, last_b, busy_b, done_b;
   logic [15:0] feat_b;
   logic [15:0] data_b;
   exp_t        q_b[$];

   conv_feature_streamer #(.DATA_WIDTH(16), .WORDS(1)) u_b (
      .clk(clk), .reset(rst), .start(start_b), .featIn(feat_b),
      .outData(data_b), .outValid(valid_b), .outReady(ready_b),
      .outLast(last_b), .busy(busy_b), .done(done_b));

   // ---------------- instance C: WORDS=288
   logic          start_c, ready_c, valid_c, last_c, busy_c, done_c;
   logic [4607:0] feat_c;
   logic [15:0]   data_c;
   exp_t          q_c[$];

   conv_feature_streamer #(.DATA_WIDTH(16), .WORDS(288)) u_c (
      .clk(clk), .reset(rst), .start(start_c), .featIn(feat_c),
      .outData(data_c), .outValid(valid_c), .outReady(ready_c),
      .outLast(last_c), .busy(busy_c), .done(done_c));

   // Monitors: pop and compare on every transfer, check stall stability
   logic        stall_a = 1'b0;
   logic [15:0] pdata_a;
   logic        plast_a;
   always @(negedge clk) begin
      exp_t e;
      if (done_a) done_cnt_a++;
      if (stall_a && valid_a) begin
         chk("a_stall_data", 32'(data_a), 32'(pdata_a));
         chk("a_stall_last", 32'(last_a), 32'(plast_a));
      end
      if (valid_a && ready_a) begin
         if (q_a.size() == 0) begin
            chk("a_unexpected_word", 32'(data_a), 32'hDEAD_BEEF);
         end else begin
            e = q_a.pop_front();
            chk("a_data", 32'(data_a), 32'(e.d));
            chk("a_last", 32'(last_a), 32'(e.l));
         end
      end
      stall_a = valid_a && !ready_a;
      pdata_a = data_a;
      plast_a = last_a;
   end

   always @(negedge clk) begin
      exp_t e;
      if (valid_b && ready_b) begin
         if (q_b.size() == 0) begin
            chk("b_unexpected_word", 32'(data_b), 32'hDEAD_BEEF);
         end else begin
            e = q_b.pop_front();
            chk("b_data", 32'(data_b), 32'(e.d));
            chk("b_last", 32'(last_b), 32'(e.l));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (valid_c && ready_c) begin
         if (q_c.size() == 0) begin
            chk("c_unexpected_word", 32'(data_c), 32'hDEAD_BEEF);
         end else begin
            e = q_c.pop_front();
            chk("c_data", 32'(data_c), 32'(e.d));
            chk("c_last", 32'(last_c), 32'(e.l));
         end
      end
   end

   task automatic push_a4();
      for (int i = 1; i <= 4; i++) begin
         q_a.push_back({16'(i), (i == 4)});
      end
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
   endtask

   // Drive ready (optionally 1,0,0,1 pattern) until done, then check the tail
   task automatic run_a(input string tag, input bit toggle, input int exp_cycles);
      int n;
      int d0;
      n  = 0;
      d0 = done_cnt_a;
      while (!done_a && n < 100) begin
         ready_a = toggle ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
         @(posedge clk); #1;
         n++;
      end
      ready_a = 1'b1;
      chk({tag, "_done_seen"}, 32'(done_a), 32'd1);
      chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
      chk({tag, "_busy_in_done"}, 32'(busy_a), 32'd1);
      @(posedge clk); #1;
      chk({tag, "_done_pulse_len"}, 32'(done_a), 32'd0);
      chk({tag, "_busy_fall"}, 32'(busy_a), 32'd0);
      chk({tag, "_done_count"}, 32'(done_cnt_a - d0), 32'd1);
      chk({tag, "_queue_empty"}, 32'(q_a.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
      feat_a = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
      feat_b = 16'h8001;
      for (int i = 0; i < 288; i++) feat_c[i*16 +: 16] = 16'(i);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(valid_a), 32'd0);
      chk("rst_data",  32'(data_a),  32'd0);
      chk("rst_last",  32'(last_a),  32'd0);
      chk("rst_busy",  32'(busy_a),  32'd0);
      chk("rst_done",  32'(done_a),  32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: straight stream, ready held high
      push_a4();
      pulse_start_a();
      chk("t1_lat_valid", 32'(valid_a), 32'd1);
      chk("t1_lat_data",  32'(data_a),  32'h0001);
      chk("t1_lat_busy",  32'(busy_a),  32'd1);
      run_a("t1", 1'b0, 4);

      // 2: ready toggling 1,0,0,1
      push_a4();
      pulse_start_a();
      run_a("t2", 1'b1, 8);

      // 3: featIn changed and start re-pulsed mid-stream
      push_a4();
      pulse_start_a();
      ready_a = 1'b0;
      feat_a  = {4{16'hFFFF}};
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      run_a("t3", 1'b0, 4);
      repeat (2) @(posedge clk);
      #1;
      chk("t3_no_restart", 32'(valid_a), 32'd0);
      feat_a = {16'h0004, 16'h0003, 16'h0002, 16'h0001};

      // 4: reset after two transfers
      push_a4();
      n = done_cnt_a;
      pulse_start_a();
      ready_a = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      ready_a = 1'b0;
      rst     = 1'b1;
      @(posedge clk); #1;
      chk("t4_valid", 32'(valid_a), 32'd0);
      chk("t4_data",  32'(data_a),  32'd0);
      chk("t4_last",  32'(last_a),  32'd0);
      chk("t4_busy",  32'(busy_a),  32'd0);
      chk("t4_popped_two", 32'(q_a.size()), 32'd2);
      q_a.delete();
      rst     = 1'b0;
      ready_a = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t4_no_done", 32'(done_cnt_a - n), 32'd0);
      push_a4();
      pulse_start_a();
      run_a("t4b", 1'b0, 4);

      // 5: single-word instance
      q_b.push_back({16'h8001, 1'b1});
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      chk("t5_last", 32'(last_b), 32'd1);
      n = 0;
      while (!done_b && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t5_cycles", 32'(n), 32'd1);
      chk("t5_queue_empty", 32'(q_b.size()), 32'd0);
      @(posedge clk); #1;
      chk("t5_busy_fall", 32'(busy_b), 32'd0);

      // 6: full 288-word map, word i = i
      for (int i = 0; i < 288; i++) q_c.push_back({16'(i), (i == 287)});
      start_c = 1'b1;
      @(posedge clk); #1;
      start_c = 1'b0;
      n = 0;
      while (!done_c && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t6_cycles", 32'(n), 32'd288);
      chk("t6_queue_empty", 32'(q_c.size()), 32'd0);
      @(posedge clk); #1;
      chk("t6_busy_fall", 32'(busy_c), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_conv_feature_streamer
